ttl_74194: RTL and testbench
============================

TTL_74194 -- requirements
Module: ttl_74194

Interface
REQ-001 SHALL declare no parameters; width is fixed at 4 bits, matching the 74194 device.
REQ-002 SHALL have port clk, input, 1: system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port CLK, input, 1: device clock pin, sampled on clk.
REQ-005 SHALL have port CLR_N, input, 1: device clear pin, active low.
REQ-006 SHALL have port S0, input, 1: mode select, bit 0.
REQ-007 SHALL have port S1, input, 1: mode select, bit 1.
REQ-008 SHALL have port SR, input, 1: shift-right serial data in.
REQ-009 SHALL have port SL, input, 1: shift-left serial data in.
REQ-010 SHALL have ports A, B, C, D, input, 1 each: parallel data in.
REQ-011 SHALL have ports QA, QB, QC, QD, output, 1 each: register outputs.

Function
REQ-012 SHALL register CLK into clk_prev every clk cycle; a device edge is CLK==1 && clk_prev==0.
REQ-013 SHALL apply an accepted device edge to QA..QD on the same clk edge that detects it; outputs are visible one clk after CLK is sampled high.
REQ-014 SHALL decode S1:S0 at the detecting clk edge: 00 = hold; 01 = shift right; 10 = shift left; 11 = parallel load.
REQ-015 SHALL perform shift right as QA<=SR, QB<=QA, QC<=QB, QD<=QC.
REQ-016 SHALL perform shift left as QD<=SL, QC<=QD, QB<=QC, QA<=QB.
REQ-017 SHALL perform load as QA<=A, QB<=B, QC<=C, QD<=D.
REQ-018 SHALL, while CLR_N==0, force QA..QD to 0 on every clk edge regardless of CLK; device edges during clear are discarded.
REQ-019 SHALL continue tracking clk_prev while CLR_N==0, so releasing CLR_N with CLK held high produces no edge.
REQ-020 SHALL ignore mode, serial and parallel inputs when no device edge is detected; QA..QD hold.
REQ-021 SHALL accept at most one device edge per clk cycle; a CLK high pulse shorter than one clk period may be lost, which is acceptable.
REQ-022 SHALL apply priority reset > CLR_N low > device edge > hold.

Reset
REQ-023 SHALL, while reset==1, drive QA..QD to 0 on each clk edge.
REQ-024 SHALL, while reset==1, load clk_prev with the current CLK, so that no false edge occurs on the first cycle after reset.
REQ-025 SHALL discard a device edge that coincides with reset.
REQ-026 SHALL, when reset is asserted in the middle of operation, clear to 0 on the next clk edge with no partial shift retained.

Structure
REQ-027 SHALL place mode encodings (HOLD = 2'b00, SHR = 2'b01, SHL = 2'b10, LOAD = 2'b11) in the shared package ttl_pkg.
REQ-028 SHALL instantiate one sub-module, ttl_edge_det (CLK sampler plus rising-edge pulse), for reuse by later edge-clocked TTL models.
REQ-029 SHALL be otherwise flat, with a single 4-bit state register; outputs are driven directly from that register with no combinational path from inputs.

Verification
REQ-030 SHALL verify: reset=1 for 2 clk with CLK=1, then reset=0 with CLK held 1 -> Q stays 0000 and no shift occurs.
REQ-031 SHALL verify: S=11, ABCD=1010, one CLK pulse -> QA..QD=1010 one clk after CLK rises; a second pulse with S=00 -> 1010 held.
REQ-032 SHALL verify: from 1010, S=01, SR=1, three CLK pulses -> 1101, then 1110, then 1111.
REQ-033 SHALL verify: from 0001, S=10, SL=0, one CLK pulse -> 0010; with SL=1, a further pulse -> 0101.
REQ-034 SHALL verify: CLR_N=0 asserted while CLK toggles with S=11 and ABCD=1111 -> Q=0000 throughout; CLR_N released while CLK=1 -> Q stays 0000 until the next rising CLK.
REQ-035 SHALL verify: CLK rises in the same cycle that reset asserts, with S=11 -> Q=0000, and no load is applied after reset releases.

Source files
------------

// File: rtl/ttl_pkg.sv
// Shared definitions for the edge-clocked TTL device models.
package ttl_pkg;

    // Mode select encoding as seen on {S1, S0}.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } ttl_mode_e;

    localparam int TTL_REG_W = 4;

    // Shift a register toward its low index (QA toward QD), inserting at the top.
    function automatic logic [TTL_REG_W-1:0] shift_toward_low(
        input logic [TTL_REG_W-1:0] cur,
        input logic                 fill
    );
        return {fill, cur[TTL_REG_W-1:1]};
    endfunction

    // Shift a register toward its high index (QD toward QA), inserting at the bottom.
    function automatic logic [TTL_REG_W-1:0] shift_toward_high(
        input logic [TTL_REG_W-1:0] cur,
        input logic                 fill
    );
        return {cur[TTL_REG_W-2:0], fill};
    endfunction

endpackage

// File: rtl/ttl_edge_det.sv
// Samples a slow device clock pin on the system clock and flags its rising edge.
// The previous sample is kept up to date unconditionally (including during reset),
// so a pin already high when reset or clear releases never produces a false edge.
module ttl_edge_det (
    input  logic clk,
    input  logic sig_in,
    output logic rise
);

    logic sample_q;
    logic sample_d;

    // Next sample is always the current pin level.
    always_comb begin
        sample_d = sig_in;
    end

    // Hold last cycle's pin level.
    always_ff @(posedge clk) begin
        sample_q <= sample_d;
    end

    assign rise = sig_in & ~sample_q;

endmodule

// File: rtl/ttl_74194.sv
// 4-bit bidirectional universal shift register (74194), modelled synchronously:
// the device CLK pin is sampled on clk and a rising CLK acts on the same clk edge.
// Bit ordering inside the register is q[3]=QA ... q[0]=QD.
module ttl_74194
    import ttl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic CLK,
    input  logic CLR_N,
    input  logic S0,
    input  logic S1,
    input  logic SR,
    input  logic SL,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD
);

    logic                 dev_edge;
    logic [TTL_REG_W-1:0] q_q;
    logic [TTL_REG_W-1:0] q_d;
    ttl_mode_e            mode;

    ttl_edge_det u_edge_det (
        .clk    (clk),
        .sig_in (CLK),
        .rise   (dev_edge)
    );

    assign mode = ttl_mode_e'({S1, S0});

    // Next register value: clear beats a device edge, and no edge means hold.
    always_comb begin
        q_d = q_q;
        if (!CLR_N) begin
            q_d = '0;
        end else if (dev_edge) begin
            case (mode)
                HOLD:    q_d = q_q;
                SHR:     q_d = shift_toward_low(q_q, SR);
                SHL:     q_d = shift_toward_high(q_q, SL);
                LOAD:    q_d = {A, B, C, D};
                default: q_d = q_q;
            endcase
        end
    end

    // State register; reset wins over everything and drops any coincident edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign QA = q_q[3];
    assign QB = q_q[2];
    assign QC = q_q[1];
    assign QD = q_q[0];

endmodule

// File: tb/tb_ttl_74194.sv
// Directed self-checking bench for ttl_74194.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_ttl_74194;

    logic clk;
    logic reset;
    logic CLK;
    logic CLR_N;
    logic S0, S1;
    logic SR, SL;
    logic A, B, C, D;
    logic QA, QB, QC, QD;

    int checkCount;
    int errorCount;

    ttl_74194 dut (
        .clk   (clk),
        .reset (reset),
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .S0    (S0),
        .S1    (S1),
        .SR    (SR),
        .SL    (SL),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .QA    (QA),
        .QB    (QB),
        .QC    (QC),
        .QD    (QD)
    );

    // System clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare observed {QA,QB,QC,QD} against the hand-computed value.
    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    // Set mode, serial and parallel inputs.
    task automatic applyStimulus(input logic [1:0] s, input logic sr, input logic sl, input logic [3:0] abcd);
        {S1, S0}     = s;
        SR           = sr;
        SL           = sl;
        {A, B, C, D} = abcd;
    endtask

    // Advance one clk period, ending on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Raise CLK, check the result one clk later, then lower CLK for a clk.
    task automatic pulseAndCheck(input string tag, input logic [3:0] expected);
        CLK = 1'b1;
        tick();
        checkOutput(tag, {QA, QB, QC, QD}, expected);
        CLK = 1'b0;
        tick();
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset = 1'b1;
        CLK   = 1'b1;
        CLR_N = 1'b1;
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b1111);

        // Reset for two clks with CLK high; releasing with CLK still high gives no edge.
        tick();
        tick();
        checkOutput("reset_state", {QA, QB, QC, QD}, 4'b0000);
        reset = 1'b0;
        tick();
        checkOutput("no_false_edge_1", {QA, QB, QC, QD}, 4'b0000);
        tick();
        checkOutput("no_false_edge_2", {QA, QB, QC, QD}, 4'b0000);
        CLK = 1'b0;
        tick();

        // Parallel load, checking nothing changes before the detecting clk edge.
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b1010);
        CLK = 1'b1;
        checkOutput("pre_edge", {QA, QB, QC, QD}, 4'b0000);
        tick();
        checkOutput("load_1010", {QA, QB, QC, QD}, 4'b1010);
        CLK = 1'b0;
        tick();
        applyStimulus(2'b00, 1'b1, 1'b1, 4'b0101);
        pulseAndCheck("hold_1010", 4'b1010);

        // Inputs are ignored without a device edge.
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b0000);
        tick();
        tick();
        checkOutput("no_edge_ignore", {QA, QB, QC, QD}, 4'b1010);

        // Shift right from 1010 with SR=1.
        applyStimulus(2'b01, 1'b1, 1'b0, 4'b0000);
        pulseAndCheck("shr_1", 4'b1101);
        pulseAndCheck("shr_2", 4'b1110);
        pulseAndCheck("shr_3", 4'b1111);

        // Shift left from 0001.
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b0001);
        pulseAndCheck("load_0001", 4'b0001);
        applyStimulus(2'b10, 1'b0, 1'b0, 4'b0000);
        pulseAndCheck("shl_sl0", 4'b0010);
        applyStimulus(2'b10, 1'b0, 1'b1, 4'b0000);
        pulseAndCheck("shl_sl1", 4'b0101);

        // Clear held low while CLK toggles with a load pending.
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b1111);
        CLR_N = 1'b0;
        tick();
        checkOutput("clr_enter", {QA, QB, QC, QD}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            CLK = ~CLK;
            tick();
            checkOutput("clr_toggle", {QA, QB, QC, QD}, 4'b0000);
        end
        CLK = 1'b1;
        tick();
        checkOutput("clr_clk_high", {QA, QB, QC, QD}, 4'b0000);
        CLR_N = 1'b1;
        tick();
        checkOutput("clr_release_1", {QA, QB, QC, QD}, 4'b0000);
        tick();
        checkOutput("clr_release_2", {QA, QB, QC, QD}, 4'b0000);
        CLK = 1'b0;
        tick();
        checkOutput("clr_release_low", {QA, QB, QC, QD}, 4'b0000);
        pulseAndCheck("after_clr_load", 4'b1111);

        // Reset mid-operation coinciding with a CLK rise and a pending load.
        applyStimulus(2'b11, 1'b0, 1'b0, 4'b1010);
        reset = 1'b1;
        CLK   = 1'b1;
        tick();
        checkOutput("reset_edge", {QA, QB, QC, QD}, 4'b0000);
        reset = 1'b0;
        tick();
        checkOutput("reset_edge_rel_1", {QA, QB, QC, QD}, 4'b0000);
        tick();
        checkOutput("reset_edge_rel_2", {QA, QB, QC, QD}, 4'b0000);
        CLK = 1'b0;
        tick();
        pulseAndCheck("post_reset_load", 4'b1010);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
